// File: rtl/btn_cond_pkg.sv
// Shared timing defaults, counter-width helper and channel state encoding
// for the push-button conditioner.
`timescale 1ns/1ps
package btn_cond_pkg;

   localparam int unsigned DEF_DEBOUNCE_CYC = 32'd65535;
   localparam int unsigned DEF_HOLD_CYC     = 32'd50_000_000;
   localparam int unsigned DEF_REPEAT_CYC   = 32'd10_000_000;

   // Bits needed to count 0..n-1, never less than one bit.
   function automatic int unsigned ctr_w(input int unsigned n);
      return (n < 32'd2) ? 32'd1 : 32'($clog2(n));
   endfunction

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESSED   = 2'd1,
      HOLDING   = 2'd2,
      REPEATING = 2'd3
   } ch_state_e;

endpackage

// File: rtl/button_conditioner_if.sv
// Button bus: raw pins in, conditioned level and strobes out.
`timescale 1ns/1ps
interface button_conditioner_if #(
   parameter int unsigned N = 5
);
   logic [N-1:0] btn_in;
   logic [N-1:0] btn_level;
   logic [N-1:0] btn_press;
   logic [N-1:0] btn_release;
   logic [N-1:0] btn_repeat;

   modport master (
      output btn_in,
      input  btn_level, btn_press, btn_release, btn_repeat
   );

   modport slave (
      input  btn_in,
      output btn_level, btn_press, btn_release, btn_repeat
   );
endinterface

// File: rtl/button_channel.sv
// One button: two-flop synchroniser, symmetric debounce, press/release
// strobes and hold/auto-repeat sequencing.
`timescale 1ns/1ps
module button_channel
   import btn_cond_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
   parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_pin,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_repeat
);

   localparam int unsigned DB_W     = ctr_w(DEBOUNCE_CYC);
   localparam int unsigned HOLD_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
   localparam int unsigned HOLD_W   = ctr_w(HOLD_MAX + 32'd1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 32'd1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 32'd1);
   localparam logic [HOLD_W-1:0] REP_LAST  =
      HOLD_W'((REPEAT_CYC == 32'd0) ? 32'd0 : REPEAT_CYC - 32'd1);

   logic              r_s1, r_s2;
   logic [DB_W-1:0]   r_cnt;
   logic              r_level, r_press, r_release, r_repeat;
   logic [HOLD_W-1:0] r_hold;
   ch_state_e         r_state;

   logic [DB_W-1:0]   w_cnt_n;
   logic              w_level_n, w_press_n, w_release_n, w_repeat_n;
   logic [HOLD_W-1:0] w_hold_n;
   ch_state_e         w_state_n;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_repeat  <= 1'b0;
         r_hold    <= '0;
         r_state   <= IDLE;
      end else begin
         r_s1      <= i_pin;
         r_s2      <= r_s1;
         r_cnt     <= w_cnt_n;
         r_level   <= w_level_n;
         r_press   <= w_press_n;
         r_release <= w_release_n;
         r_repeat  <= w_repeat_n;
         r_hold    <= w_hold_n;
         r_state   <= w_state_n;
      end
   end

   // Debounce and hold/repeat sequencing; a release always beats a due repeat
   always_comb begin
      w_cnt_n     = '0;
      w_level_n   = r_level;
      w_press_n   = 1'b0;
      w_release_n = 1'b0;
      w_repeat_n  = 1'b0;
      w_hold_n    = r_hold;
      w_state_n   = r_state;

      if (r_s2 != r_level) begin
         if (r_cnt == DB_LAST) begin
            w_level_n   = r_s2;
            w_press_n   = r_s2;
            w_release_n = ~r_s2;
         end else begin
            w_cnt_n = r_cnt + DB_W'(1);
         end
      end

      case (r_state)
         IDLE: begin
            w_hold_n = '0;
            if (w_press_n) w_state_n = PRESSED;
         end
         PRESSED: begin
            if (w_release_n) begin
               w_state_n = IDLE;
               w_hold_n  = '0;
            end else if (r_hold == HOLD_LAST) begin
               w_repeat_n = 1'b1;
               if (REPEAT_CYC == 32'd0) begin
                  w_state_n = HOLDING;
               end else begin
                  w_state_n = REPEATING;
                  w_hold_n  = '0;
               end
            end else begin
               w_hold_n = r_hold + HOLD_W'(1);
            end
         end
         REPEATING: begin
            if (w_release_n) begin
               w_state_n = IDLE;
               w_hold_n  = '0;
            end else if (r_hold == REP_LAST) begin
               w_repeat_n = 1'b1;
               w_hold_n   = '0;
            end else begin
               w_hold_n = r_hold + HOLD_W'(1);
            end
         end
         HOLDING: begin
            if (w_release_n) begin
               w_state_n = IDLE;
               w_hold_n  = '0;
            end
         end
         default: begin
            w_state_n = IDLE;
            w_hold_n  = '0;
         end
      endcase
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_repeat  = r_repeat;

endmodule

// File: rtl/button_conditioner.sv
// N-channel push-button conditioner: pin polarity fix-up followed by one
// independent button_channel per pin.
`timescale 1ns/1ps
module button_conditioner
   import btn_cond_pkg::*;
#(
   parameter int unsigned N            = 32'd5,
   parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
   parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC,
   parameter bit          ACTIVE_LOW   = 1'b0
) (
   input logic                 clk,
   input logic                 rst_n,
   button_conditioner_if.slave bus
);

   if (N < 32'd1) begin : g_bad_n
      $error("button_conditioner: N must be at least 1");
   end
   if (DEBOUNCE_CYC < 32'd2) begin : g_bad_db
      $error("button_conditioner: DEBOUNCE_CYC must be at least 2");
   end
   if (HOLD_CYC < 32'd2) begin : g_bad_hold
      $error("button_conditioner: HOLD_CYC must be at least 2");
   end

   logic [N-1:0] w_pol;
   logic [N-1:0] w_level, w_press, w_release, w_repeat;

   assign w_pol = bus.btn_in ^ {N{ACTIVE_LOW}};

   for (genvar gi = 0; gi < int'(N); gi++) begin : g_ch
      button_channel #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .HOLD_CYC     (HOLD_CYC),
         .REPEAT_CYC   (REPEAT_CYC)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_pin     (w_pol[gi]),
         .o_level   (w_level[gi]),
         .o_press   (w_press[gi]),
         .o_release (w_release[gi]),
         .o_repeat  (w_repeat[gi])
      );
   end

   assign bus.btn_level   = w_level;
   assign bus.btn_press   = w_press;
   assign bus.btn_release = w_release;
   assign bus.btn_repeat  = w_repeat;

endmodule
